// File: rtl/dram_wb_bist.sv
// dram_wb_bist: Wishbone classic initiator that writes an LFSR pattern over an
// address window of the DRAM user port, reads it back and counts mismatches.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   start                      1-cycle pulse, begins a test when idle/done
//   base_addr, length, seed    window start, word count, LFSR seed (0 -> 1)
//   busy, done, timeout        test status (done/timeout sticky until next start)
//   err_count, first_err_addr  saturating error count and first failing address
//   wb_*                       Wishbone classic initiator signals
//
// Optional feature: define DRAM_BIST_INVERT_PASS_EN to add a second write+read
// pass with inverted data so every bit is exercised at both 0 and 1.
module dram_wb_bist #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [DATA_WIDTH-1:0] wb_dat_w,
  input  logic [DATA_WIDTH-1:0] wb_dat_r,
  output logic [3:0]            wb_sel,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  input  logic                  wb_ack,
  input  logic                  wb_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  // Galois taps for x^32+x^22+x^2+x+1 (right-shifting form)
  localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(32'h8020_0003);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_GAP, S_READ, S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [DATA_WIDTH-1:0] r_lfsr;
  logic [TW-1:0]         r_to_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_timeout;
  logic [15:0]           r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat_w;
  logic                  r_cyc;
  logic                  r_we;

  logic [DATA_WIDTH-1:0] w_lfsr_next;
  logic [DATA_WIDTH-1:0] w_pat_next;
  logic [DATA_WIDTH-1:0] w_exp;
  logic [DATA_WIDTH-1:0] w_seed_eff;
  logic                  w_resp;
  logic                  w_last;
  logic                  w_hit;

  assign w_lfsr_next = {1'b0, r_lfsr[DATA_WIDTH-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  assign w_seed_eff  = (seed == '0) ? DATA_WIDTH'(1) : seed;
  // err takes priority over ack; either one completes the transfer
  assign w_resp      = wb_ack | wb_err;
  assign w_last      = (ADDR_WIDTH'(r_idx + 1'b1) == r_len);

`ifdef DRAM_BIST_INVERT_PASS_EN
  logic r_inv;
  logic r_gap_to_rd;
  assign w_pat_next = r_inv ? ~w_lfsr_next : w_lfsr_next;
  assign w_exp      = r_inv ? ~r_lfsr : r_lfsr;
`else
  assign w_pat_next = w_lfsr_next;
  assign w_exp      = r_lfsr;
`endif

  // A bus error always counts; read data is only compared when no error
  assign w_hit = wb_err | ((r_state == S_READ) && (wb_dat_r != w_exp));

  // Test sequencer with registered bus and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_seed      <= DATA_WIDTH'(1);
      r_lfsr      <= DATA_WIDTH'(1);
      r_to_cnt    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_count <= '0;
      r_first_err <= '0;
      r_adr       <= '0;
      r_dat_w     <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
`ifdef DRAM_BIST_INVERT_PASS_EN
      r_inv       <= 1'b0;
      r_gap_to_rd <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_base      <= base_addr;
            r_len       <= length;
            r_seed      <= w_seed_eff;
            r_lfsr      <= w_seed_eff;
            r_idx       <= '0;
            r_to_cnt    <= '0;
`ifdef DRAM_BIST_INVERT_PASS_EN
            r_inv       <= 1'b0;
`endif
            if (length == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WRITE;
              r_busy  <= 1'b1;
              r_cyc   <= 1'b1;
              r_we    <= 1'b1;
              r_adr   <= base_addr;
              r_dat_w <= w_seed_eff;
            end
          end
        end

        S_WRITE, S_READ: begin
          if (w_resp) begin
            r_to_cnt <= '0;
            r_lfsr   <= w_lfsr_next;
            r_idx    <= ADDR_WIDTH'(r_idx + 1'b1);
            if (w_hit) begin
              if (r_err_count == '0) r_first_err <= r_adr;
              if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
            if (w_last) begin
              r_cyc <= 1'b0;
              r_we  <= 1'b0;
              if (r_state == S_WRITE) begin
                r_state <= S_GAP;
`ifdef DRAM_BIST_INVERT_PASS_EN
                r_gap_to_rd <= 1'b1;
`endif
              end else begin
`ifdef DRAM_BIST_INVERT_PASS_EN
                if (!r_inv) begin
                  r_state     <= S_GAP;
                  r_inv       <= 1'b1;
                  r_gap_to_rd <= 1'b0;
                end else begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
`else
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
`endif
              end
            end else begin
              // next word presented immediately, stb stays high
              r_adr <= ADDR_WIDTH'(r_adr + 1'b1);
              if (r_state == S_WRITE) r_dat_w <= w_pat_next;
            end
          end else if (r_to_cnt == TO_LAST) begin
            // slave stalled too long: abandon the rest of the test
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_to_cnt <= TW'(r_to_cnt + 1'b1);
          end
        end

        S_GAP: begin
          r_lfsr   <= r_seed;
          r_idx    <= '0;
          r_to_cnt <= '0;
          r_adr    <= r_base;
          r_cyc    <= 1'b1;
`ifdef DRAM_BIST_INVERT_PASS_EN
          if (r_gap_to_rd) begin
            r_state <= S_READ;
            r_we    <= 1'b0;
            r_dat_w <= '0;
          end else begin
            r_state <= S_WRITE;
            r_we    <= 1'b1;
            r_dat_w <= ~r_seed;
          end
`else
          r_state <= S_READ;
          r_we    <= 1'b0;
          r_dat_w <= '0;
`endif
        end

        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign timeout        = r_timeout;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err;
  assign wb_adr         = r_adr;
  assign wb_dat_w       = r_dat_w;
  assign wb_sel         = 4'hF;
  assign wb_cyc         = r_cyc;
  assign wb_stb         = r_cyc;
  assign wb_we          = r_we;

endmodule

// File: tb/tb_dram_wb_bist.sv
// tb_dram_wb_bist: directed bench for dram_wb_bist with a zero-wait Wishbone
// memory slave that can stall, flip a read bit, or return err on a read.
module tb_dram_wb_bist;

  localparam int unsigned AW = 30;
  localparam int unsigned TO = 16;
`ifdef DRAM_BIST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic [31:0]   seed = '0;
  logic          busy, done, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr, wb_adr;
  logic [31:0]   wb_dat_w, wb_dat_r;
  logic [3:0]    wb_sel;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_err;

  // slave fault controls
  logic          hold_en = 1'b0;
  logic [AW-1:0] hold_adr = '0;
  logic          flip_en = 1'b0;
  logic [AW-1:0] flip_adr = '0;
  logic          err_en = 1'b0;
  logic [AW-1:0] err_adr = '0;

  logic [31:0]   mem [16];

  dram_wb_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .seed(seed), .busy(busy), .done(done), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr), .wb_adr(wb_adr),
    .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel), .wb_cyc(wb_cyc),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  assign wb_ack   = wb_cyc & wb_stb & ~(hold_en && (wb_adr == hold_adr));
  assign wb_err   = wb_cyc & wb_stb & ~wb_we & err_en & (wb_adr == err_adr);
  assign wb_dat_r = mem[wb_adr[3:0]] ^ {31'b0, (flip_en && (wb_adr == flip_adr))};

  // transfer log and activity counters
  logic          q_we  [$];
  logic [AW-1:0] q_adr [$];
  logic [31:0]   q_dat [$];
  int            cyc_cycles = 0;
  int            hold_cycles = 0;

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && (wb_ack || wb_err)) begin
      q_we.push_back(wb_we);
      q_adr.push_back(wb_adr);
      q_dat.push_back(wb_dat_w);
      if (wb_we) mem[wb_adr[3:0]] <= wb_dat_w;
    end
    if (wb_cyc) cyc_cycles <= cyc_cycles + 1;
    if (wb_cyc && wb_stb && !wb_ack && !wb_err) hold_cycles <= hold_cycles + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0]       base;
    logic [AW-1:0]       len;
    logic [31:0]         seed;
    logic                flip_en;
    logic [AW-1:0]       flip_adr;
    logic                err_en;
    logic [AW-1:0]       err_adr;
    int                  exp_err;
    logic [AW-1:0]       exp_first;
    logic [3:0][AW-1:0]  exp_adr;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] pat  [4];

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] l,
                             input logic [31:0] s);
    @(posedge clk); #1;
    base_addr = b; length = l; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 500; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   s, c0, n, ph, k;
    logic [31:0] ed;
    v = vecs[vi];
    flip_en = v.flip_en; flip_adr = v.flip_adr;
    err_en  = v.err_en;  err_adr  = v.err_adr;
    hold_en = 1'b0;
    s  = q_we.size();
    c0 = cyc_cycles;
    pulse_start(v.base, v.len, v.seed);
    chk($sformatf("v%0d_cyc_first", vi), 64'({wb_cyc, wb_stb, busy}), 64'b111);
    wait_done($sformatf("v%0d", vi));
    @(negedge clk);
    chk($sformatf("v%0d_idle_bus", vi), 64'({wb_cyc, wb_stb, busy, timeout}), 64'b0);
    chk($sformatf("v%0d_err_count", vi), 64'(err_count), 64'(v.exp_err));
    chk($sformatf("v%0d_first_err", vi), 64'(first_err_addr), 64'(v.exp_first));
    n = q_we.size() - s;
    chk($sformatf("v%0d_tx_count", vi), 64'(n), 64'(2 * int'(v.len) * NPASS));
    // zero-wait slave: one cyc cycle per transfer, no bubbles inside a phase
    chk($sformatf("v%0d_cyc_cycles", vi), 64'(cyc_cycles - c0), 64'(n));
    if (n == 2 * int'(v.len) * NPASS) begin
      for (int t = 0; t < n; t++) begin
        ph = t / int'(v.len);
        k  = t % int'(v.len);
        chk($sformatf("v%0d_tx%0d_we_adr", vi, t), 64'({q_we[s+t], q_adr[s+t]}),
            64'({(ph % 2) == 0, v.exp_adr[k]}));
        if ((ph % 2) == 0) begin
          ed = (ph == 0) ? pat[k] : ~pat[k];
          chk($sformatf("v%0d_tx%0d_wdata", vi, t), 64'(q_dat[s+t]), 64'(ed));
        end
      end
    end
    flip_en = 1'b0; err_en = 1'b0;
  endtask

  initial begin
    int s, c0, h0;
    // LFSR sequence from seed 1 (seed 0 is promoted to 1)
    pat[0] = 32'h0000_0001;
    pat[1] = 32'h8020_0003;
    pat[2] = 32'hC030_0002;
    pat[3] = 32'h6018_0001;

    vecs[0] = '{base: 30'h100, len: 30'd4, seed: 32'd1, flip_en: 1'b0, flip_adr: '0,
                err_en: 1'b0, err_adr: '0, exp_err: 0, exp_first: '0,
                exp_adr: {30'h103, 30'h102, 30'h101, 30'h100}};
    vecs[1] = '{base: 30'h100, len: 30'd4, seed: 32'd1, flip_en: 1'b1, flip_adr: 30'h102,
                err_en: 1'b0, err_adr: '0, exp_err: NPASS, exp_first: 30'h102,
                exp_adr: {30'h103, 30'h102, 30'h101, 30'h100}};
    vecs[2] = '{base: 30'h3FFF_FFFE, len: 30'd4, seed: 32'd0, flip_en: 1'b0, flip_adr: '0,
                err_en: 1'b0, err_adr: '0, exp_err: 0, exp_first: '0,
                exp_adr: {30'h1, 30'h0, 30'h3FFF_FFFF, 30'h3FFF_FFFE}};
    vecs[3] = '{base: 30'h200, len: 30'd2, seed: 32'd1, flip_en: 1'b0, flip_adr: '0,
                err_en: 1'b0, err_adr: '0, exp_err: 0, exp_first: '0,
                exp_adr: {30'h0, 30'h0, 30'h201, 30'h200}};
    vecs[4] = '{base: 30'h100, len: 30'd4, seed: 32'd1, flip_en: 1'b0, flip_adr: '0,
                err_en: 1'b1, err_adr: 30'h101, exp_err: NPASS, exp_first: 30'h101,
                exp_adr: {30'h103, 30'h102, 30'h101, 30'h100}};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_status", 64'({busy, done, timeout}), 64'b0);
    chk("rst_err", 64'({err_count, first_err_addr}), 64'b0);
    chk("rst_bus", 64'({wb_cyc, wb_stb, wb_we, wb_adr}), 64'b0);
    chk("rst_dat_w", 64'(wb_dat_w), 64'd0);
    chk("rst_sel", 64'(wb_sel), 64'hF);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // length 0: done one cycle after start, no bus activity, status cleared
    c0 = cyc_cycles;
    pulse_start(30'h100, 30'd0, 32'd1);
    chk("len0_done", 64'({done, busy, wb_cyc}), 64'b100);
    chk("len0_status", 64'({timeout, err_count, first_err_addr}), 64'b0);
    repeat (4) @(negedge clk);
    chk("len0_no_cyc", 64'(cyc_cycles - c0), 64'd0);

    // stalled 3rd write: abort after TIMEOUT cycles, no read phase
    hold_en = 1'b1; hold_adr = 30'h102;
    s  = q_we.size();
    h0 = hold_cycles;
    c0 = cyc_cycles;
    pulse_start(30'h100, 30'd4, 32'd1);
    wait_done("to");
    @(negedge clk);
    chk("to_flags", 64'({timeout, done, busy, wb_cyc, wb_stb}), 64'b11000);
    chk("to_stall_cycles", 64'(hold_cycles - h0), 64'(TO));
    chk("to_tx_count", 64'(q_we.size() - s), 64'd2);
    repeat (4) @(negedge clk);
    chk("to_cyc_total", 64'(cyc_cycles - c0), 64'(2 + TO));
    chk("to_err_count", 64'(err_count), 64'd0);
    hold_en = 1'b0;

    // start clears a sticky timeout
    run_vec(0);

    // async reset in the middle of the read phase
    flip_en = 1'b1; flip_adr = 30'h100;
    pulse_start(30'h100, 30'd4, 32'd1);
    for (int i = 0; i < 100; i++) begin
      if (wb_cyc && !wb_we) break;
      @(negedge clk);
    end
    chk("mid_read_reached", 64'({wb_cyc, wb_we}), 64'b10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bus", 64'({wb_cyc, wb_stb, busy, done}), 64'b0);
    chk("arst_status", 64'({timeout, err_count, first_err_addr}), 64'b0);
    flip_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
